// File: rtl/mult_acc_if.sv
// -----------------------------------------------------------------------------
// mult_acc_if
//   Handshake/bus bundle between a pipelined multiplier's control side and the
//   frame accumulator (mult_acc).
//
//   Signals
//     in_valid   operand pair presented to the multiplier this cycle
//     in_last    presented pair closes the frame
//     in_ready   accumulator can take a new operand pair (combinational)
//     pdt        product arriving from the multiplier, 2*SIZE bits
//     acc_out    frame sum, ACC_W = 2*SIZE+GUARD bits
//     out_valid  frame sum available
//     out_ready  consumer accepts acc_out
//     ovf        frame sum exceeded ACC_W bits
//
//   Modports
//     master : operand source / multiplier / consumer side
//     slave  : the accumulator (mult_acc)
// -----------------------------------------------------------------------------
interface mult_acc_if #(
    parameter int SIZE  = 16,
    parameter int GUARD = 8
);
    localparam int ACC_W = 2 * SIZE + GUARD;

    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [2*SIZE-1:0]    pdt;
    logic [ACC_W-1:0]     acc_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 ovf;

    modport master (
        output in_valid,
        output in_last,
        output pdt,
        output out_ready,
        input  in_ready,
        input  acc_out,
        input  out_valid,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  pdt,
        input  out_ready,
        output in_ready,
        output acc_out,
        output out_valid,
        output ovf
    );
endinterface

// File: rtl/mult_acc.sv
// -----------------------------------------------------------------------------
// mult_acc
//   Downstream stage of a fixed-latency pipelined multiplier. Sums the products
//   of one frame (the pair flagged in_last closes it) and then holds the sum
//   on a valid/ready output until the consumer takes it. The multiplier cannot
//   stall, so the accept/last flags are delayed internally by LVL clocks to
//   line up with pdt, and in_ready throttles the operand source instead.
//   All arithmetic is unsigned.
//
//   Parameters
//     SIZE   operand width; pdt is 2*SIZE bits
//     LVL    multiplier latency in clocks from operand sample to pdt (>= 1)
//     GUARD  extra accumulator MSBs; ACC_W = 2*SIZE+GUARD (>= 1)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous reset, active-low
//     bus    mult_acc_if.slave:
//              in_valid/in_last/in_ready  operand-side handshake
//              pdt                        product, LVL clocks after operands
//              acc_out/out_valid/out_ready/ovf  result handshake
//
//   Configuration macro
//     MULT_ACC_SAT_EN  defined: an overflowing add clamps the sum to all-ones
//                      for the rest of the frame.
//                      undefined: the sum wraps modulo 2^ACC_W.
//                      ovf is reported either way; ports are identical.
// -----------------------------------------------------------------------------
module mult_acc #(
    parameter int SIZE  = 16,
    parameter int LVL   = 2,
    parameter int GUARD = 8
) (
    input logic     clk,
    input logic     rst_n,
    mult_acc_if.slave bus
);
    localparam int PDT_W = 2 * SIZE;
    localparam int ACC_W = PDT_W + GUARD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;

    // Delay line for the accept and accept&last flags. Bit LVL-1 is the tap
    // that coincides with the matching product on pdt.
    logic [LVL-1:0]     vld_q,   vld_d;
    logic [LVL-1:0]     lst_q,   lst_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic               in_ready_c;
    logic               accept;
    logic               tap_vld;
    logic               tap_lst;
    logic [ACC_W-1:0]   pdt_ext;
    logic [ACC_W:0]     sum_ext;
    logic               carry;

    // New frames are held off while a last is still travelling down the delay
    // line, which guarantees no product can arrive while the sum is held.
    assign in_ready_c = (state_q != S_HOLD) && (lst_q == '0);
    assign accept     = bus.in_valid && in_ready_c;

    assign tap_vld    = vld_q[LVL-1];
    assign tap_lst    = lst_q[LVL-1];

    assign pdt_ext    = ACC_W'(bus.pdt);
    assign sum_ext    = {1'b0, acc_q} + {1'b0, pdt_ext};
    assign carry      = sum_ext[ACC_W];

    // -------------------------------------------------------------------------
    // Delay line next-state
    // -------------------------------------------------------------------------
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = accept;
        lst_d[0] = accept && bus.in_last;
        for (int i = 1; i < LVL; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                // First product of a frame loads the accumulator directly;
                // a single product can never overflow ACC_W bits.
                if (tap_vld) begin
                    acc_d   = pdt_ext;
                    state_d = tap_lst ? S_HOLD : S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (tap_vld) begin
                    ovf_d = ovf_q | carry;
`ifdef MULT_ACC_SAT_EN
                    // Once saturated the sum stays pinned for the whole frame,
                    // even if later products happen to be zero.
                    if (carry || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
`else
                    acc_d = sum_ext[ACC_W-1:0];
`endif
                    if (tap_lst) begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            lst_q   <= lst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // acc_q cannot change in HOLD, so driving it straight out keeps acc_out
    // frozen for the whole output handshake.
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.acc_out   = acc_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_mult_acc
//   Self-checking bench for mult_acc (SIZE=16, LVL=2, GUARD=8). A pipelined
//   multiplier model feeds pdt; expected frame sums come from plain integer
//   arithmetic on the operand pairs sent.
// -----------------------------------------------------------------------------
module tb_mult_acc;
    localparam int SIZE  = 16;
    localparam int LVL   = 2;
    localparam int GUARD = 8;
    localparam int ACC_W = 2 * SIZE + GUARD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_acc_if #(.SIZE(SIZE), .GUARD(GUARD)) bus ();

    mult_acc #(.SIZE(SIZE), .LVL(LVL), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier model: samples operands every edge, product appears LVL
    // clocks later, never stalls.
    logic [SIZE-1:0]   op_a = '0;
    logic [SIZE-1:0]   op_b = '0;
    logic [2*SIZE-1:0] mpipe [LVL];

    initial begin
        for (int i = 0; i < LVL; i++) mpipe[i] = '0;
    end

    always @(posedge clk) begin
        mpipe[0] <= op_a * op_b;
        for (int i = 1; i < LVL; i++) mpipe[i] <= mpipe[i-1];
    end

    assign bus.pdt = mpipe[LVL-1];

    int errors = 0;
    int checks = 0;

    // Reference model of a frame result from the exact (unbounded) sum.
    function automatic logic [ACC_W-1:0] model_acc(input longint unsigned sum);
        logic [ACC_W-1:0] r;
`ifdef MULT_ACC_SAT_EN
        if (sum >= (64'd1 << ACC_W)) r = '1;
        else                         r = ACC_W'(sum % (64'd1 << ACC_W));
`else
        r = ACC_W'(sum % (64'd1 << ACC_W));
`endif
        return r;
    endfunction

    function automatic logic model_ovf(input longint unsigned sum);
        return sum >= (64'd1 << ACC_W);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pair and hold it until accepted (bounded).
    task automatic send_pair(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                             input logic last);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        op_a = a;
        op_b = b;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            errors++;
            $display("FAIL send_pair_timeout in_ready=%b required=1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait for out_valid, hold it off for 'stall' cycles checking stability,
    // then complete the handshake.
    task automatic wait_result(input int stall, output logic [ACC_W-1:0] acc,
                               output logic ov);
        int waited;
        waited = 0;
        bus.out_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        checks++;
        if (waited >= 50) begin
            errors++;
            $display("FAIL result_timeout out_valid=%b required=1", bus.out_valid);
        end
        acc = bus.acc_out;
        ov  = bus.ovf;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_ready got=%b required=0", bus.in_ready);
        end
        for (int i = 0; i < stall; i++) begin
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.acc_out !== acc || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable out_valid=%b acc_out=%h in_ready=%b required 1/%h/0",
                         bus.out_valid, bus.acc_out, bus.in_ready, acc);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_release out_valid=%b in_ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.acc_out !== '0 || bus.ovf !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state out_valid=%b acc_out=%h ovf=%b in_ready=%b required 0/0/0/1",
                     bus.out_valid, bus.acc_out, bus.ovf, bus.in_ready);
        end
        rst_n = 1'b1;
        $display("reset: out_valid=%b acc_out=%h ovf=%b in_ready=%b",
                 bus.out_valid, bus.acc_out, bus.ovf, bus.in_ready);
    endtask

    // Frame (3,4),(5,6),(7,8): sum 98, out_valid on the (LVL+1)th edge
    // counting the edge that accepted the last pair, visible one cycle.
    task automatic test_basic_frame();
        bus.out_ready = 1'b1;
        send_pair(16'd3, 16'd4, 1'b0);
        send_pair(16'd5, 16'd6, 1'b0);
        send_pair(16'd7, 16'd8, 1'b1);
        // one edge since accept of last
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_last in_ready=%b out_valid=%b required 0/0",
                     bus.in_ready, bus.out_valid);
        end
        step();  // two edges
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid out_valid=%b required=0", bus.out_valid);
        end
        step();  // three edges
        checks++;
        if (bus.out_valid !== 1'b1 || bus.acc_out !== 40'd98 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result out_valid=%b acc_out=%0d ovf=%b required 1/98/0",
                     bus.out_valid, bus.acc_out, bus.ovf);
        end
        $display("frame basic: acc_out=%0d ovf=%b", bus.acc_out, bus.ovf);
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_one_cycle out_valid=%b in_ready=%b required 0/1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    // Same frame held for 5 cycles; in_valid driven during HOLD must be ignored.
    task automatic test_hold_backpressure();
        int waited;
        bus.out_ready = 1'b0;
        send_pair(16'd3, 16'd4, 1'b0);
        send_pair(16'd5, 16'd6, 1'b0);
        send_pair(16'd7, 16'd8, 1'b1);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        bus.in_valid = 1'b1;
        op_a = 16'd100;
        op_b = 16'd100;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.acc_out !== 40'd98 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d out_valid=%b acc_out=%0d in_ready=%b required 1/98/0",
                         i, bus.out_valid, bus.acc_out, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release in_ready=%b out_valid=%b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
        $display("frame hold: released in_ready=%b", bus.in_ready);
        // Nothing stray may have been accumulated from the ignored in_valid.
        send_pair(16'd1, 16'd1, 1'b1);
        begin
            logic [ACC_W-1:0] acc;
            logic ov;
            wait_result(0, acc, ov);
            checks++;
            if (acc !== 40'd1 || ov !== 1'b0) begin
                errors++;
                $display("FAIL hold_ignored_input acc_out=%h ovf=%b required 1/0", acc, ov);
            end
        end
    endtask

    task automatic test_single_max();
        logic [ACC_W-1:0] acc;
        logic ov;
        send_pair(16'hFFFF, 16'hFFFF, 1'b1);
        wait_result(1, acc, ov);
        checks++;
        if (acc !== 40'h00FFFE0001 || ov !== 1'b0) begin
            errors++;
            $display("FAIL single_max acc_out=%h ovf=%b required 00fffe0001/0", acc, ov);
        end
        $display("frame single: acc_out=%h ovf=%b", acc, ov);
    endtask

    // 257 full-scale pairs back to back overflow the 40-bit accumulator.
    task automatic test_back_to_back_overflow();
        logic [ACC_W-1:0] acc;
        logic ov;
        longint unsigned sum;
        logic [ACC_W-1:0] exp_acc;
        sum = 0;
        for (int i = 0; i < 257; i++) begin
            send_pair(16'hFFFF, 16'hFFFF, (i == 256));
            sum += longint'(32'hFFFE0001);
        end
        wait_result(2, acc, ov);
`ifdef MULT_ACC_SAT_EN
        exp_acc = 40'hFFFFFFFFFF;
`else
        exp_acc = 40'h00FDFE0101;
`endif
        checks++;
        if (acc !== exp_acc || acc !== model_acc(sum) || ov !== 1'b1) begin
            errors++;
            $display("FAIL overflow_frame acc_out=%h ovf=%b required %h/1", acc, ov, exp_acc);
        end
        $display("frame overflow: acc_out=%h ovf=%b", acc, ov);
    endtask

    task automatic test_reset_midframe();
        logic [ACC_W-1:0] acc;
        logic ov;
        int waited;
        bus.out_ready = 1'b1;
        send_pair(16'd9, 16'd9, 1'b0);
        send_pair(16'd9, 16'd9, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.acc_out !== '0 || bus.ovf !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset out_valid=%b acc_out=%h ovf=%b in_ready=%b required 0/0/0/1",
                     bus.out_valid, bus.acc_out, bus.ovf, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        send_pair(16'd2, 16'd2, 1'b1);
        wait_result(0, acc, ov);
        checks++;
        if (acc !== 40'd4 || ov !== 1'b0) begin
            errors++;
            $display("FAIL after_midframe_reset acc_out=%0d ovf=%b required 4/0", acc, ov);
        end
        $display("frame after reset: acc_out=%0d ovf=%b", acc, ov);

        // Reset while holding a result.
        send_pair(16'd5, 16'd5, 1'b1);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.acc_out !== '0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_reset out_valid=%b acc_out=%h in_ready=%b required 0/0/1",
                     bus.out_valid, bus.acc_out, bus.in_ready);
        end
    endtask

    // Random frames with bubbles and random output stalls.
    task automatic test_random_frames();
        logic [ACC_W-1:0] acc;
        logic ov;
        longint unsigned sum;
        int len;
        logic [SIZE-1:0] a, b;
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 12);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                a = SIZE'($urandom);
                b = SIZE'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    op_a = SIZE'($urandom);
                    op_b = SIZE'($urandom);
                    repeat ($urandom_range(1, 3)) step();
                end
                send_pair(a, b, (i == len - 1));
                sum += longint'(a) * longint'(b);
            end
            wait_result($urandom_range(0, 4), acc, ov);
            checks++;
            if (acc !== model_acc(sum) || ov !== model_ovf(sum)) begin
                errors++;
                $display("FAIL random_frame%0d acc_out=%h ovf=%b required %h/%b",
                         f, acc, ov, model_acc(sum), model_ovf(sum));
            end
            $display("frame random%0d len=%0d: acc_out=%h ovf=%b", f, len, acc, ov);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_hold_backpressure();
        test_single_max();
        test_back_to_back_overflow();
        test_random_frames();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
